// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared memory bus widths, arbiter state encoding and helpers
package bus_pkg;

  localparam int BUS_DATA_WIDTH_SHIFT = 4;
  localparam int BUS_DATA_WIDTH       = 128;
  localparam int BUS_STRB_WIDTH       = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way request pick with last-winner register
module rr_arbiter2 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       win_d_i,
  output logic [1:0] pick_o
);

  // Starts as "D served last" so port I wins the first conflict.
  logic last_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_d <= 1'b1;
    end else if (update_i) begin
      last_d <= win_d_i;
    end
  end

  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01: pick_o = 2'b01;
      2'b10: pick_o = 2'b10;
      2'b11: begin
        if ((ROUND_ROBIN != 0) && !last_d) pick_o = 2'b10;
        else                               pick_o = 2'b01;
      end
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D port arbiter for the 128-bit four-phase memory bus
// Optional grant/wait counters when MEM_BUS_ARB_STATS_EN is defined.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH = 20,
  parameter int ROUND_ROBIN       = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] i_addr_i,
  input  logic                                          i_valid_i,
  output logic [BUS_DATA_WIDTH-1:0]                     i_data_o,
  output logic                                          i_valid_o,
  input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] d_addr_i,
  input  logic                                          d_we_i,
  input  logic [BUS_DATA_WIDTH-1:0]                     d_wdata_i,
  input  logic [BUS_STRB_WIDTH-1:0]                     d_wstrb_i,
  input  logic                                          d_valid_i,
  output logic [BUS_DATA_WIDTH-1:0]                     d_data_o,
  output logic                                          d_valid_o,
  output logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] mem_addr_o,
  output logic                                          mem_we_o,
  output logic [BUS_DATA_WIDTH-1:0]                     mem_wdata_o,
  output logic [BUS_STRB_WIDTH-1:0]                     mem_wstrb_o,
  output logic                                          mem_valid_o,
  input  logic [BUS_DATA_WIDTH-1:0]                     mem_data_i,
  input  logic                                          mem_valid_i,
`ifdef MEM_BUS_ARB_STATS_EN
  output logic [31:0]                                   stat_i_grants_o,
  output logic [31:0]                                   stat_d_grants_o,
  output logic [31:0]                                   stat_wait_cycles_o,
`endif
  output logic [1:0]                                    grant_o
);

  arb_state_t state;
  logic [1:0] pick;
  logic       granted_valid;
  logic       release_done;

  assign granted_valid = (grant_o[0] & i_valid_i) | (grant_o[1] & d_valid_i);
  assign release_done  = (state == ARB_RELEASE) && !mem_valid_i;

  rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({d_valid_i, i_valid_i}),
    .update_i (release_done),
    .win_d_i  (grant_o[1]),
    .pick_o   (pick)
  );

  // Acks only reach the granted port; an ack seen with no grant is dropped.
  assign i_valid_o = mem_valid_i & grant_o[0];
  assign d_valid_o = mem_valid_i & grant_o[1];
  assign i_data_o  = mem_data_i;
  assign d_data_o  = mem_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ARB_IDLE;
      grant_o     <= 2'b00;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|pick) begin
            grant_o     <= pick;
            mem_valid_o <= 1'b1;
            state       <= ARB_GRANT;
            if (pick[1]) begin
              mem_addr_o  <= d_addr_i;
              mem_we_o    <= d_we_i;
              mem_wdata_o <= d_wdata_i;
              mem_wstrb_o <= d_wstrb_i;
            end else begin
              // Port I is read-only, so its transfers never write.
              mem_addr_o  <= i_addr_i;
              mem_we_o    <= 1'b0;
              mem_wdata_o <= '0;
              mem_wstrb_o <= '0;
            end
          end
        end
        ARB_GRANT: begin
          mem_valid_o <= granted_valid;
          if (!granted_valid) state <= ARB_RELEASE;
        end
        ARB_RELEASE: begin
          if (!mem_valid_i) begin
            grant_o <= 2'b00;
            state   <= ARB_IDLE;
          end
        end
        default: begin
          grant_o     <= 2'b00;
          mem_valid_o <= 1'b0;
          state       <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_BUS_ARB_STATS_EN
  logic waiting;
  logic grant_i_now;
  logic grant_d_now;

  assign waiting     = (i_valid_i & ~grant_o[0]) | (d_valid_i & ~grant_o[1]);
  assign grant_i_now = (state == ARB_IDLE) & pick[0];
  assign grant_d_now = (state == ARB_IDLE) & pick[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_i_grants_o    <= 32'd0;
      stat_d_grants_o    <= 32'd0;
      stat_wait_cycles_o <= 32'd0;
    end else begin
      if (grant_i_now) stat_i_grants_o    <= sat_inc32(stat_i_grants_o);
      if (grant_d_now) stat_d_grants_o    <= sat_inc32(stat_d_grants_o);
      if (waiting)     stat_wait_cycles_o <= sat_inc32(stat_wait_cycles_o);
    end
  end
`endif

endmodule
